// File: rtl/fir_pkg.sv
// Shared widths, FSM encoding, output beat payload and coefficient/saturation helpers
// for the 2x polyphase interpolating FIR.
package fir_pkg;

  localparam int unsigned DW     = 16;
  localparam int unsigned NTAPS  = 16;
  localparam int unsigned NPH    = NTAPS / 2;
  localparam int unsigned KW     = $clog2(NPH);
  localparam int unsigned CIDX_W = $clog2(NTAPS);
  localparam int unsigned CW     = 16;
  localparam int unsigned PW     = DW + CW;
  localparam int unsigned ACC_W  = 36;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MAC_E = 3'd1,
    ST_OUT_E = 3'd2,
    ST_MAC_O = 3'd3,
    ST_OUT_O = 3'd4
  } state_t;

  typedef struct packed {
    logic                 phase;
    logic signed [DW-1:0] data;
  } out_beat_t;

  // Prototype coefficients h[0..15], indexed by {k, p} = 2k+p.
  function automatic logic signed [CW-1:0] coef_lut(input logic [CIDX_W-1:0] idx);
    case (idx)
      4'd0:    coef_lut = 16'sd512;
      4'd1:    coef_lut = 16'sd1024;
      4'd2:    coef_lut = 16'sd2048;
      4'd3:    coef_lut = 16'sd4096;
      4'd4:    coef_lut = 16'sd8192;
      4'd5:    coef_lut = 16'sd4096;
      4'd6:    coef_lut = 16'sd2048;
      4'd7:    coef_lut = 16'sd1024;
      4'd8:    coef_lut = 16'sd512;
      4'd9:    coef_lut = 16'sd256;
      4'd10:   coef_lut = 16'sd128;
      4'd11:   coef_lut = 16'sd64;
      4'd12:   coef_lut = 16'sd32;
      4'd13:   coef_lut = 16'sd16;
      4'd14:   coef_lut = 16'sd8;
      default: coef_lut = 16'sd4;
    endcase
  endfunction

  // Clamp an already-shifted accumulator value into the signed DW range.
  function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-DW:0] top;
    top = v[ACC_W-1:DW-1];
    if ((&top) || (~|top))
      sat_dw = v[DW-1:0];
    else if (v[ACC_W-1])
      sat_dw = {1'b1, {(DW-1){1'b0}}};
    else
      sat_dw = {1'b0, {(DW-1){1'b1}}};
  endfunction

endpackage

// File: rtl/fir_coeff_rom.sv
// Combinational polyphase coefficient lookup: returns h[2k+p].
module fir_coeff_rom
  import fir_pkg::*;
(
  input  logic [KW-1:0]        k,
  input  logic                 p,
  output logic signed [CW-1:0] coef_c
);

  assign coef_c = coef_lut({k, p});

endmodule

// File: rtl/fir_interp2_16tap.sv
// 2x polyphase interpolating FIR: one shared multiplier, 8 MAC cycles per output phase,
// valid/ready on both sides.
module fir_interp2_16tap
  import fir_pkg::*;
#(
  parameter int unsigned SHIFT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic                 out_phase,
  output logic                 busy
);

  state_t                  state, state_d;
  logic signed [DW-1:0]    hist [NPH];
  logic signed [ACC_W-1:0] acc, acc_d;
  logic [KW-1:0]           k, k_d;
  out_beat_t               out_q, out_d;
  logic                    out_valid_d;
  logic                    hist_shift;

  logic                    mac_p_c;
  logic signed [CW-1:0]    coef_c;
  logic signed [DW-1:0]    hist_k_c;
  logic signed [PW-1:0]    prod_c;
  logic signed [ACC_W-1:0] mac_sum_c;
  logic signed [ACC_W-1:0] shifted_c;

  assign mac_p_c = (state == ST_MAC_O);

  fir_coeff_rom u_coeff_rom (
    .k      (k),
    .p      (mac_p_c),
    .coef_c (coef_c)
  );

  // Single MAC datapath shared by both phases; floor shift then clamp.
  assign hist_k_c  = hist[k];
  assign prod_c    = PW'(hist_k_c) * PW'(coef_c);
  assign mac_sum_c = acc + ACC_W'(prod_c);
  assign shifted_c = mac_sum_c >>> SHIFT;

  assign out_data  = out_q.data;
  assign out_phase = out_q.phase;

  always_comb begin
    state_d     = state;
    acc_d       = acc;
    k_d         = k;
    out_d       = out_q;
    out_valid_d = out_valid;
    hist_shift  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          hist_shift = 1'b1;
          acc_d      = '0;
          k_d        = '0;
          state_d    = ST_MAC_E;
        end
      end
      ST_MAC_E, ST_MAC_O: begin
        acc_d = mac_sum_c;
        k_d   = k + KW'(1);
        if (k == KW'(NPH - 1)) begin
          out_d.data  = sat_dw(shifted_c);
          out_d.phase = mac_p_c;
          out_valid_d = 1'b1;
          state_d     = mac_p_c ? ST_OUT_O : ST_OUT_E;
        end
      end
      ST_OUT_E: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          k_d         = '0;
          state_d     = ST_MAC_O;
        end
      end
      ST_OUT_O: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      acc       <= '0;
      k         <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      k         <= k_d;
      out_q     <= out_d;
      out_valid <= out_valid_d;
      in_ready  <= (state_d == ST_IDLE);
      busy      <= (state_d != ST_IDLE);
    end
  end

  // Sample history delay line, newest sample at hist[0].
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NPH); i++) hist[i] <= '0;
    end else if (hist_shift) begin
      hist[0] <= in_data;
      for (int i = 1; i < int'(NPH); i++) hist[i] <= hist[i-1];
    end
  end

endmodule

// File: tb/tb_fir_interp2_16tap.sv
// Self-checking bench for fir_interp2_16tap: directed vector table, timing/backpressure/
// saturation/reset corner sequences, and a random run against a behavioural model.
module tb_fir_interp2_16tap;

  localparam int COEF [16] = '{512, 1024, 2048, 4096, 8192, 4096, 2048, 1024,
                               512, 256, 128, 64, 32, 16, 8, 4};

  typedef struct {
    int x;
    int e;
    int o;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               out_ready;
  logic               in_ready, out_valid, out_phase, busy;
  logic signed [15:0] out_data;
  logic               s_in_ready, s_out_valid, s_out_phase, s_busy;
  logic signed [15:0] s_out_data;

  int checks = 0;
  int failures = 0;
  int mh [8];
  vec_t tbl [13];

  always #5 clk = ~clk;

  fir_interp2_16tap u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_phase(out_phase), .busy(busy)
  );

  fir_interp2_16tap #(.SHIFT(12)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_phase(s_out_phase), .busy(s_busy)
  );

  task automatic check(input string name, input logic signed [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns just after the rising edge at which the sample was accepted.
  task automatic send(input int x);
    bit seen, ok;
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'(x);
    for (int i = 0; i < 200 && !ok; i++) begin
      if (i > 0) @(negedge clk);
      seen = in_ready;
      @(posedge clk);
      ok = seen;
    end
    #1 in_valid = 1'b0;
    if (!ok) timeout("send");
  endtask

  task automatic get(input int stall, output int d, output int p, output int sd, output int sp);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) timeout("get");
    d = int'(out_data); p = int'(out_phase); sd = int'(s_out_data); sp = int'(s_out_phase);
    if (stall > 0) begin
      out_ready = 1'b0;
      repeat (stall) @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic int model(input int p);
    longint s;
    s = 0;
    for (int k = 0; k < 8; k++) s += longint'(mh[k]) * longint'(COEF[2*k+p]);
    s = s >>> 15;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic run_table(input int n, input string tag);
    int d, p, sd, sp;
    for (int i = 0; i < n; i++) begin
      send(tbl[i].x);
      get(0, d, p, sd, sp);
      check($sformatf("%s_even[%0d]", tag, i), d, tbl[i].e);
      check($sformatf("%s_ph_e[%0d]", tag, i), p, 0);
      get(0, d, p, sd, sp);
      check($sformatf("%s_odd[%0d]", tag, i), d, tbl[i].o);
      check($sformatf("%s_ph_o[%0d]", tag, i), p, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, p, sd, sp;
    int t_e, t_o, t_r;
    bit sv, si, hold_ok, leak;

    tbl[0]  = '{16384, 256, 512};
    tbl[1]  = '{0, 1024, 2048};
    tbl[2]  = '{0, 4096, 2048};
    tbl[3]  = '{0, 1024, 512};
    tbl[4]  = '{0, 256, 128};
    tbl[5]  = '{0, 64, 32};
    tbl[6]  = '{0, 16, 8};
    tbl[7]  = '{0, 4, 2};
    tbl[8]  = '{0, 0, 0};
    tbl[9]  = '{-1, -1, -1};
    tbl[10] = '{1, -1, -1};
    tbl[11] = '{-16384, -257, -512};
    tbl[12] = '{32767, -512, -1024};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_phase", out_phase, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    run_table(13, "vec");

    // Edge counts from the accept edge to the first edge that sees each signal high.
    do_reset();
    send(0);
    t_e = 0; t_o = 0; t_r = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      sv = out_valid; si = in_ready;
      @(posedge clk);
      if (sv) begin
        if (t_e == 0) t_e = n;
        else if (t_o == 0) t_o = n;
      end
      if (si) begin
        t_r = n;
        break;
      end
    end
    check("lat_even", t_e, 9);
    check("lat_odd", t_o - t_e, 9);
    check("next_in_ready", t_r, 19);

    do_reset();
    out_ready = 1'b0;
    send(16384);
    sv = 1'b0;
    for (int i = 0; i < 40 && !sv; i++) begin
      @(negedge clk);
      sv = out_valid;
    end
    check("bp_valid", sv, 1);
    in_valid = 1'b1; in_data = 16'sd12345;
    hold_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!(out_valid && out_data == 16'sd256 && !out_phase && !in_ready && busy)) hold_ok = 1'b0;
    end
    check("bp_hold", hold_ok, 1);
    check("bp_data", out_data, 256);
    in_valid = 1'b0;
    out_ready = 1'b1;
    get(0, d, p, sd, sp);
    check("bp_odd", d, 512);
    check("bp_odd_ph", p, 1);
    send(0);
    get(0, d, p, sd, sp);
    check("bp_next_even", d, 1024);
    get(0, d, p, sd, sp);
    check("bp_next_odd", d, 2048);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(32767);
      get(0, d, p, sd, sp);
      if (i == 7) begin
        check("sat_pos_even", sd, 32767);
        check("nosat_pos_even", d, 13479);
        check("lockstep_busy", s_busy, int'(busy));
        check("lockstep_ready", s_in_ready, int'(in_ready));
      end
      get(0, d, p, sd, sp);
      if (i == 7) begin
        check("sat_pos_odd", sd, 32767);
        check("sat_pos_odd_ph", sp, 1);
        check("nosat_pos_odd", d, 10579);
      end
    end
    for (int i = 0; i < 8; i++) begin
      send(-32768);
      get(0, d, p, sd, sp);
      if (i == 7) begin
        check("sat_neg_even", sd, -32768);
        check("nosat_neg_even", d, -13480);
      end
      get(0, d, p, sd, sp);
      if (i == 7) begin
        check("sat_neg_odd", sd, -32768);
        check("nosat_neg_odd", d, -10580);
      end
    end

    do_reset();
    send(16384);
    get(0, d, p, sd, sp);
    check("abort_even", d, 256);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    rst = 1'b0;
    leak = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) leak = 1'b1;
    end
    check("abort_no_odd", leak, 0);
    run_table(8, "reimp");

    do_reset();
    for (int i = 0; i < 8; i++) mh[i] = 0;
    for (int i = 0; i < 200; i++) begin
      int x;
      x = int'($signed(16'($urandom)));
      send(x);
      for (int j = 7; j > 0; j--) mh[j] = mh[j-1];
      mh[0] = x;
      get(int'($urandom_range(0, 2)), d, p, sd, sp);
      check($sformatf("rand_even[%0d]", i), d, model(0));
      get(int'($urandom_range(0, 2)), d, p, sd, sp);
      check($sformatf("rand_odd[%0d]", i), d, model(1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
